// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues sequential PCs to a fixed-latency imem,
// tracks outstanding reads, buffers returned words and hands them to decode.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (sticky fault on misaligned redirect).
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_LAT   = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_rd_en_o,
  output logic [31:0] imem_pc_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        fetch_fault_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]         pc_q, pc_d;
  logic [IMEM_LAT-1:0] infl_vld_q, infl_vld_d;
  logic [31:0]         infl_pc_q [IMEM_LAT];
  logic [31:0]         infl_pc_d [IMEM_LAT];
  logic [31:0]         mem_instr_q [FIFO_DEPTH];
  logic [31:0]         mem_pc_q [FIFO_DEPTH];
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_inc;
  logic [CntW-1:0]     count_q, count_d;
  logic [31:0]         head_instr_q, head_instr_d, head_pc_q, head_pc_d;
  logic                fault_q, fault_d;
  logic [31:0]         redir_pc;
  logic                redir_mis;
  int unsigned         infl_cnt;
  logic                issue, push, pop;

`ifdef FETCH_MISALIGN_CHK_EN
  assign redir_pc  = redirect_pc_i;
  assign redir_mis = |redirect_pc_i[1:0];

  if (RESET_PC[1:0] != 2'b00) begin : gen_reset_pc_chk
    $error("RESET_PC must be word aligned");
  end
`else
  // Low address bits are simply dropped; no fault can be raised.
  assign redir_pc  = redirect_pc_i & 32'hFFFF_FFFC;
  assign redir_mis = 1'b0;
`endif

  assign imem_rd_en_o  = rst_n;
  assign imem_pc_o     = pc_q;
  assign out_valid_o   = (count_q != '0);
  assign out_instr_o   = head_instr_q;
  assign out_pc_o      = head_pc_q;
  assign fetch_fault_o = fault_q;

  // Count outstanding reads; each one holds a reserved FIFO slot.
  always_comb begin
    infl_cnt = 0;
    for (int i = 0; i < IMEM_LAT; i++) begin
      infl_cnt = infl_cnt + 32'(infl_vld_q[i]);
    end
  end

  assign issue      = !redirect_valid_i && !fault_q &&
                      ((32'(count_q) + infl_cnt) < FIFO_DEPTH);
  assign push       = infl_vld_q[IMEM_LAT-1] && !redirect_valid_i;
  assign pop        = (count_q != '0) && out_ready_i;
  assign rd_ptr_inc = rd_ptr_q + PtrW'(1);

  // Next-state: PC advance, inflight shift, FIFO pointers and registered head.
  always_comb begin
    pc_d         = pc_q;
    infl_vld_d   = infl_vld_q;
    infl_pc_d    = infl_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    fault_d      = fault_q;
    if (redirect_valid_i) begin
      // Flush everything; the head register keeps its last value.
      pc_d       = redir_pc;
      fault_d    = redir_mis;
      infl_vld_d = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      for (int i = IMEM_LAT - 1; i > 0; i--) begin
        infl_vld_d[i] = infl_vld_q[i-1];
        infl_pc_d[i]  = infl_pc_q[i-1];
      end
      infl_vld_d[0] = issue;
      infl_pc_d[0]  = pc_q;
      if (issue) pc_d = pc_q + 32'd4;
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_d = rd_ptr_inc;
      count_d = count_q + CntW'(push) - CntW'(pop);
      // Head follows the oldest remaining entry, or the incoming word if none remains.
      if (pop && (count_q > CntW'(1))) begin
        head_instr_d = mem_instr_q[rd_ptr_inc];
        head_pc_d    = mem_pc_q[rd_ptr_inc];
      end else if (push && ((count_q == '0) || (pop && (count_q == CntW'(1))))) begin
        head_instr_d = imem_instr_i;
        head_pc_d    = infl_pc_q[IMEM_LAT-1];
      end
    end
  end

  // Control and head state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      infl_vld_q   <= '0;
      for (int i = 0; i < IMEM_LAT; i++) infl_pc_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      fault_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      infl_vld_q   <= infl_vld_d;
      infl_pc_q    <= infl_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      fault_q      <= fault_d;
    end
  end

  // Buffer storage; only valid entries are ever read, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr_q[wr_ptr_q] <= imem_instr_i;
      mem_pc_q[wr_ptr_q]    <= infl_pc_q[IMEM_LAT-1];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a PC scoreboard and a 2-cycle imem model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_rd_en;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_fault;

  logic [31:0] mp1, mp2;
  logic [31:0] exp_q[$];
  int          checks;
  int          errors;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_LAT  (2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_rd_en_o    (imem_rd_en),
    .imem_pc_o       (imem_pc),
    .imem_instr_i    (imem_instr),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_instr_o     (out_instr),
    .out_pc_o        (out_pc),
    .fetch_fault_o   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word stored at a given address: 0x13, 0x00100093, 0x00200113, ...
  function automatic logic [31:0] word(input logic [31:0] pc);
    logic [31:0] i;
    i = pc >> 2;
    return 32'h0000_0013 + (i << 20) + (i << 7);
  endfunction

  // imem: word for the PC presented two cycles earlier.
  always @(posedge clk) begin
    mp1 <= imem_pc;
    mp2 <= mp1;
  end
  assign imem_instr = word(mp2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic check_pop();
    logic [31:0] e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL unexpected_output observed=%h expected=none", out_pc);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("out_pc", out_pc, e);
      chk("out_instr", out_instr, word(e));
    end
  endtask

  // One cycle: drive inputs mid-cycle, score the handshake taken at the next edge.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (out_valid && rdy) check_pop();
    if (redir) begin
`ifdef FETCH_MISALIGN_CHK_EN
      if (rpc[1:0] == 2'b00) fill(rpc);
      else exp_q.delete();
`else
      fill(rpc & 32'hFFFF_FFFC);
`endif
    end
  endtask

  task automatic expect_first_after_redirect(input logic [31:0] tgt);
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (k == 1) chk("redir_imem_pc", imem_pc, tgt);
      chk("redir_latency_valid", {31'b0, out_valid}, {31'b0, (k == 4)});
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) @(negedge clk);

    chk("rst_rd_en", {31'b0, imem_rd_en}, 32'h0);
    chk("rst_imem_pc", imem_pc, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'h0);

    // Release reset and stream.
    rst_n     = 1'b1;
    out_ready = 1'b1;
    fill(32'h0);
    #1;
    chk("run_rd_en", {31'b0, imem_rd_en}, 32'h1);
    chk("run_imem_pc", imem_pc, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      chk("startup_valid", {31'b0, out_valid}, {31'b0, (k == 3)});
    end
    repeat (8) begin
      cycle(1'b1, 1'b0, 32'h0);
      chk("stream_valid", {31'b0, out_valid}, 32'h1);
    end

    // Backpressure: buffer fills to four, issue stalls four words ahead of the head.
    repeat (10) cycle(1'b0, 1'b0, 32'h0);
    chk("full_valid", {31'b0, out_valid}, 32'h1);
    chk("full_head_pc", out_pc, exp_q[0]);
    chk("full_stall_pc", imem_pc, exp_q[0] + 32'd16);
    repeat (12) begin
      cycle(1'b1, 1'b0, 32'h0);
      chk("drain_no_bubble", {31'b0, out_valid}, 32'h1);
    end

    // Redirect with reads in flight and entries buffered.
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h40);
    expect_first_after_redirect(32'h40);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // Redirect coinciding with a pop handshake.
    cycle(1'b1, 1'b1, 32'h100);
    expect_first_after_redirect(32'h100);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // Asynchronous reset mid-stream.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("arst_rd_en", {31'b0, imem_rd_en}, 32'h0);
    chk("arst_imem_pc", imem_pc, 32'h0);
    chk("arst_out_pc", out_pc, 32'h0);
    chk("arst_out_instr", out_instr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fill(32'h0);
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      chk("restart_valid", {31'b0, out_valid}, {31'b0, (k == 3)});
    end
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // Misaligned redirect.
    cycle(1'b1, 1'b1, 32'h42);
`ifdef FETCH_MISALIGN_CHK_EN
    repeat (8) begin
      cycle(1'b1, 1'b0, 32'h0);
      chk("fault_set", {31'b0, fetch_fault}, 32'h1);
      chk("fault_no_valid", {31'b0, out_valid}, 32'h0);
    end
    cycle(1'b1, 1'b1, 32'h80);
    expect_first_after_redirect(32'h80);
    chk("fault_cleared", {31'b0, fetch_fault}, 32'h0);
`else
    expect_first_after_redirect(32'h40);
    chk("fault_tied_low", {31'b0, fetch_fault}, 32'h0);
`endif
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
